// File: rtl/mul_pkg.sv
// Shared definitions for the round-robin multiplier scheduler:
// FSM encoding, default sizes and the round-robin winner search.
package mul_pkg;

   localparam int MUL_WIDTH = 16;
   localparam int MUL_N_REQ = 4;
   localparam int RR_MAX    = 8;   // largest supported requester count

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

   // First set bit of valid, scanning ptr, ptr+1, ... modulo n.
   // Returns 0 when nothing is valid (caller qualifies with |valid).
   function automatic int rr_pick(input logic [RR_MAX-1:0] valid,
                                  input int ptr,
                                  input int n = MUL_N_REQ);
      int  pick;
      int  idx;
      bit  found;
      pick  = 0;
      found = 1'b0;
      for (int k = 0; k < RR_MAX; k++) begin
         if (k < n) begin
            idx = (ptr + k) % n;
            if (!found && valid[3'(idx)]) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Shift-add multiplier core: one multiplier bit per cycle after start.
// done is high during the last step; product then already includes
// that step's partial product so the owner can capture it on that edge.
module mul_shift_add_core
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int CNT_W = IDX_W + 1;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               running_reg;
   logic [2*WIDTH-1:0] addend_next;
   logic [2*WIDTH-1:0] acc_next;

   // Partial product for the current bit and the accumulator after adding it.
   always_comb begin
      addend_next = '0;
      if (running_reg && b_reg[count_reg[IDX_W-1:0]]) begin
         addend_next = {{WIDTH{1'b0}}, a_reg} << count_reg;
      end
      acc_next = acc_reg + addend_next;
   end

   assign done    = running_reg && (count_reg == CNT_W'(WIDTH - 1));
   assign product = acc_next;

   // Operand latch on start, then accumulate one bit per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg       <= '0;
         b_reg       <= '0;
         acc_reg     <= '0;
         count_reg   <= '0;
         running_reg <= 1'b0;
      end else if (start) begin
         a_reg       <= a;
         b_reg       <= b;
         acc_reg     <= '0;
         count_reg   <= '0;
         running_reg <= 1'b1;
      end else if (running_reg) begin
         acc_reg   <= acc_next;
         count_reg <= count_reg + CNT_W'(1);
         if (done) begin
            running_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler sharing one shift-add multiplier among N_REQ
// requesters. Arbitration happens in IDLE only, so req_ready has no
// path from rsp_ready; the response is registered and held in DONE.
module mul_rr_scheduler
   import mul_pkg::*;
#(
   parameter int N_REQ = MUL_N_REQ,
   parameter int WIDTH = MUL_WIDTH,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [2*WIDTH-1:0]     rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   busy
);

   mul_state_e         state_reg;
   logic [ID_W-1:0]    rr_ptr_reg;
   logic [ID_W-1:0]    id_reg;
   logic               rsp_valid_reg;
   logic [2*WIDTH-1:0] rsp_data_reg;
   logic [ID_W-1:0]    rsp_id_reg;

   logic [WIDTH-1:0]   a_arr [N_REQ];
   logic [WIDTH-1:0]   b_arr [N_REQ];
   logic [RR_MAX-1:0]  valid_pad;
   logic [ID_W-1:0]    grant_next;
   logic [ID_W-1:0]    rr_ptr_next;
   logic               accept_next;
   logic               core_done;
   logic [2*WIDTH-1:0] core_product;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
         assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
      end
      for (gi = 0; gi < RR_MAX; gi++) begin : g_pad
         if (gi < N_REQ) begin : g_used
            assign valid_pad[gi] = req_valid[gi];
         end else begin : g_unused
            assign valid_pad[gi] = 1'b0;
         end
      end
   endgenerate

   // Winner search and the one-hot accept, live only in IDLE outside reset.
   always_comb begin
      grant_next  = ID_W'(rr_pick(valid_pad, int'(rr_ptr_reg), N_REQ));
      accept_next = !rst && (state_reg == ST_IDLE) && (|req_valid);
      req_ready   = '0;
      if (accept_next) begin
         req_ready = N_REQ'(1) << grant_next;
      end
      rr_ptr_next = (grant_next == ID_W'(N_REQ - 1)) ? '0 : grant_next + ID_W'(1);
   end

   mul_shift_add_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .start   (accept_next),
      .a       (a_arr[grant_next]),
      .b       (b_arr[grant_next]),
      .done    (core_done),
      .product (core_product)
   );

   // Scheduler FSM: accept, wait for the core, then hold the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         rr_ptr_reg    <= '0;
         id_reg        <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
         rsp_id_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept_next) begin
                  id_reg     <= grant_next;
                  rr_ptr_reg <= rr_ptr_next;
                  state_reg  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (core_done) begin
                  rsp_data_reg  <= core_product;
                  rsp_id_reg    <= id_reg;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_reg <= 1'b0;
               state_reg     <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_id    = rsp_id_reg;
   assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Self-checking bench for mul_rr_scheduler: a table of hand-derived
// transactions, directed corner sequences, then randomized traffic checked
// against a round-robin / a*b reference model.
module tb_mul_rr_scheduler;

   localparam int N = 4;
   localparam int W = 16;
   localparam int LAT = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic            rsp_valid;
   logic            rsp_ready = 1'b1;
   logic [2*W-1:0]  rsp_data;
   logic [1:0]      rsp_id;
   logic            busy;

   logic [W-1:0]    op_a [N];
   logic [W-1:0]    op_b [N];

   assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
   assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;

   always #5 clk = ~clk;

   mul_rr_scheduler #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   typedef struct {
      bit              do_reset;
      logic [3:0]      valid;
      logic [W-1:0]    a [4];
      logic [W-1:0]    b [4];
      int              exp_id;
      logic [31:0]     exp_data;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: first valid requester scanning from the pointer.
   function automatic int model_pick(input logic [3:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_ptr = 0;
   endtask

   // One full transaction from IDLE; returns the observed grant and product.
   task automatic run_txn(input int stall, input bit keep, output int gid, output logic [31:0] gdata);
      int cyc;
      int lat;
      int exp_g;
      logic [31:0] exp_p;
      rsp_ready = (stall == 0);
      #1;
      cyc = 0;
      while (req_ready == '0 && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      gid = -1;
      gdata = '0;
      if (req_ready == '0) begin
         chk("grant_timeout", 64'(req_ready), 64'(1));
         return;
      end
      for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
      exp_g = model_pick(req_valid);
      chk("grant_onehot", 64'($onehot(req_ready)), 64'(1));
      chk("grant_id", 64'(gid), 64'(exp_g));
      exp_p = 32'(op_a[exp_g]) * 32'(op_b[exp_g]);
      model_ptr = (exp_g + 1) % N;
      @(posedge clk);
      #1;
      if (!keep) req_valid[gid] = 1'b0;
      chk("busy_run", 64'(busy), 64'(1));
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(LAT));
      chk("rsp_data", 64'(rsp_data), 64'(exp_p));
      chk("rsp_id", 64'(rsp_id), 64'(exp_g));
      gdata = rsp_data;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         chk("stall_valid", 64'(rsp_valid), 64'(1));
         chk("stall_data", 64'(rsp_data), 64'(exp_p));
         chk("stall_id", 64'(rsp_id), 64'(exp_g));
         chk("stall_ready0", 64'(req_ready), 64'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("rsp_drop", 64'(rsp_valid), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("ready_after_rsp", 64'(req_ready != '0), 64'(req_valid != '0));
   endtask

   task automatic set_vec(input int i, input bit r, input logic [3:0] v,
                          input logic [W-1:0] a0, input logic [W-1:0] a1,
                          input logic [W-1:0] a2, input logic [W-1:0] a3,
                          input logic [W-1:0] b0, input logic [W-1:0] b1,
                          input logic [W-1:0] b2, input logic [W-1:0] b3,
                          input int id, input logic [31:0] d);
      tbl[i].do_reset = r;
      tbl[i].valid    = v;
      tbl[i].a[0] = a0; tbl[i].a[1] = a1; tbl[i].a[2] = a2; tbl[i].a[3] = a3;
      tbl[i].b[0] = b0; tbl[i].b[1] = b1; tbl[i].b[2] = b2; tbl[i].b[3] = b3;
      tbl[i].exp_id   = id;
      tbl[i].exp_data = d;
   endtask

   initial begin
      int gid;
      logic [31:0] gdata;

      for (int i = 0; i < N; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end

      set_vec(0, 1, 4'b0001, 3, 0, 0, 0, 5, 0, 0, 0, 0, 32'd15);
      set_vec(1, 1, 4'b1111, 1, 2, 3, 4, 10, 10, 10, 10, 0, 32'd10);
      set_vec(2, 0, 4'b1110, 1, 2, 3, 4, 10, 10, 10, 10, 1, 32'd20);
      set_vec(3, 0, 4'b1100, 1, 2, 3, 4, 10, 10, 10, 10, 2, 32'd30);
      set_vec(4, 0, 4'b1000, 1, 2, 3, 4, 10, 10, 10, 10, 3, 32'd40);
      set_vec(5, 0, 4'b0100, 0, 0, 16'hFFFF, 0, 0, 0, 16'hFFFF, 0, 2, 32'hFFFE0001);
      set_vec(6, 0, 4'b0010, 0, 0, 0, 0, 0, 16'h1234, 0, 0, 1, 32'd0);
      set_vec(7, 0, 4'b1011, 11, 12, 13, 7, 2, 3, 4, 9, 3, 32'd63);
      set_vec(8, 0, 4'b1011, 11, 12, 13, 7, 2, 3, 4, 9, 0, 32'd22);
      set_vec(9, 0, 4'b1011, 11, 12, 13, 7, 2, 3, 4, 9, 1, 32'd36);

      // Reset state, including req_ready held low while rst is asserted.
      rst = 1'b1;
      req_valid = 4'b1111;
      @(posedge clk);
      #1;
      chk("ready_in_rst", 64'(req_ready), 64'(0));
      do_reset();
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_rsp_id", 64'(rsp_id), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));

      // Table-driven transactions.
      for (int t = 0; t < 10; t++) begin
         if (tbl[t].do_reset) do_reset();
         for (int i = 0; i < N; i++) begin
            op_a[i] = tbl[t].a[i];
            op_b[i] = tbl[t].b[i];
         end
         req_valid = tbl[t].valid;
         run_txn(0, 1'b0, gid, gdata);
         chk($sformatf("tbl%0d_id", t), 64'(gid), 64'(tbl[t].exp_id));
         chk($sformatf("tbl%0d_data", t), 64'(gdata), 64'(tbl[t].exp_data));
         $display("txn tbl%0d: id=%0d data=%0h", t, gid, gdata);
         req_valid = '0;
      end

      // Back-pressure: 20 stalled cycles in DONE with another requester waiting.
      op_a[0] = 16'd100; op_b[0] = 16'd7;
      op_a[1] = 16'd9;   op_b[1] = 16'd9;
      req_valid = 4'b0011;
      run_txn(20, 1'b0, gid, gdata);
      $display("txn backpressure: id=%0d data=%0h", gid, gdata);
      run_txn(0, 1'b0, gid, gdata);
      $display("txn after_release: id=%0d data=%0h", gid, gdata);
      req_valid = '0;

      // Fairness: requesters 1 and 3 continuously valid.
      do_reset();
      op_a[1] = 16'd5; op_b[1] = 16'd6;
      op_a[3] = 16'd7; op_b[3] = 16'd8;
      req_valid = 4'b1010;
      for (int k = 0; k < 8; k++) begin
         run_txn(0, 1'b1, gid, gdata);
         chk($sformatf("fair%0d_id", k), 64'(gid), 64'((k % 2 == 0) ? 1 : 3));
         $display("txn fair%0d: id=%0d data=%0h", k, gid, gdata);
      end
      req_valid = '0;

      // Move the pointer off zero, then reset at count=7 of a run.
      req_valid = 4'b0010;
      run_txn(0, 1'b0, gid, gdata);
      op_a[2] = 16'd77; op_b[2] = 16'hFFFF;
      req_valid = 4'b0100;
      #1;
      chk("mid_grant", 64'(req_ready), 64'(4'b0100));
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_ptr = 0;
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
      repeat (20) @(posedge clk);
      #1;
      chk("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
      for (int i = 0; i < N; i++) begin
         op_a[i] = 16'(i + 20);
         op_b[i] = 16'(i + 3);
      end
      req_valid = 4'b1111;
      run_txn(0, 1'b0, gid, gdata);
      chk("post_rst_ptr0", 64'(gid), 64'(0));
      chk("post_rst_data", 64'(gdata), 64'(60));
      $display("txn post_reset: id=%0d data=%0h", gid, gdata);
      req_valid = '0;

      // Randomized traffic against the reference model.
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < N; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
         end
         req_valid = 4'($urandom_range(1, 15));
         run_txn(int'($urandom_range(0, 3)), 1'b0, gid, gdata);
         $display("txn rand%0d: id=%0d data=%0h", r, gid, gdata);
      end
      req_valid = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
